// File: rtl/mmcm_drp_pkg.sv
// Shared constants for the MMCM DRP responder: bundle bit positions, DRP register
// addresses, divider field positions, the lock-state encoding and reset contents.
package mmcm_drp_pkg;

   localparam int DIN_LSB    = 0;
   localparam int DADDR_LSB  = 16;
   localparam int DEN_BIT    = 23;
   localparam int DWE_BIT    = 24;
   localparam int RST_BIT    = 25;
   localparam int DOUT_LSB   = 0;
   localparam int DRDY_BIT   = 16;
   localparam int LOCKED_BIT = 17;

   localparam logic [6:0] ADDR_LO      = 7'h06;
   localparam logic [6:0] CLKOUT0_REG1 = 7'h08;
   localparam logic [6:0] CLKOUT0_REG2 = 7'h09;
   localparam logic [6:0] CLKFB_REG1   = 7'h14;
   localparam logic [6:0] CLKFB_REG2   = 7'h15;
   localparam logic [6:0] DIVCLK_REG   = 7'h16;
   localparam logic [6:0] LOCK_REG1    = 7'h18;
   localparam logic [6:0] LOCK_REG2    = 7'h19;
   localparam logic [6:0] LOCK_REG3    = 7'h1A;
   localparam logic [6:0] POWER_REG    = 7'h28;
   localparam logic [6:0] FILT_REG1    = 7'h4E;
   localparam logic [6:0] FILT_REG2    = 7'h4F;

   localparam int HIGH_LSB           = 6;
   localparam int LOW_LSB            = 0;
   localparam int NOCOUNT_BIT        = 6;
   localparam int DIVCLK_NOCOUNT_BIT = 12;

   typedef enum logic [1:0] {
      LOCK_RESET  = 2'd0,
      LOCK_COUNT  = 2'd1,
      LOCK_LOCKED = 2'd2
   } lock_state_t;

   function automatic logic [15:0] reset_word(input logic [6:0] a);
      case (a)
         CLKOUT0_REG1, CLKFB_REG1: return 16'h0041;
         CLKOUT0_REG2, CLKFB_REG2: return 16'h0040;
         DIVCLK_REG:               return 16'h1041;
         default:                  return 16'h0000;
      endcase
   endfunction

   function automatic logic addr_legal(input logic [6:0] a);
      return (a >= ADDR_LO && a <= DIVCLK_REG) ||
             (a >= LOCK_REG1 && a <= LOCK_REG3) || (a == LOCK_REG2) ||
             (a == POWER_REG) || (a == FILT_REG1) || (a == FILT_REG2);
   endfunction

endpackage

// File: rtl/mmcm_drp_responder_div_decode.sv
// MMCM divider decode: high/low counts (0 means 64) summed, saturated at 127,
// forced to 1 when no_count is set.
module mmcm_div_decode (
   input  logic [5:0] high,
   input  logic [5:0] low,
   input  logic       no_count,
   output logic [6:0] divide
);
   logic [7:0] sum;

   always_comb begin
      sum = {1'b0, (high == 6'd0), high} + {1'b0, (low == 6'd0), low};
      if (no_count)
         divide = 7'd1;
      else if (sum > 8'd127)
         divide = 7'd127;
      else
         divide = sum[6:0];
   end
endmodule

// File: rtl/mmcm_drp_responder.sv
// MMCM DRP responder: register file, drdy timing, lock sequencing and applied dividers.
// Optional MMCM_DRP_ADDR_CHECK_EN restricts DRP access to the real MMCM address map.
//   state       | meaning
//   LOCK_RESET  | rst_mmcm held high, locked=0
//   LOCK_COUNT  | counting LOCK_CYCLES toward lock, locked=0
//   LOCK_LOCKED | locked=1 until rst_mmcm rises
module mmcm_drp_responder
   import mmcm_drp_pkg::*;
#(
   parameter int DRDY_LATENCY = 3,
   parameter int LOCK_CYCLES  = 64
) (
   input  logic        mgmt_clk,
   input  logic        mgmt_reset_n,
   input  logic [63:0] reconfig_to_pll,
   output logic [63:0] reconfig_from_pll,
   output logic [6:0]  out0_div,
   output logic [6:0]  fb_mult,
   output logic [6:0]  divclk_div,
   output logic        drp_err
);
   localparam logic [3:0] LAT_LOAD = 4'(DRDY_LATENCY - 1);
   localparam int         LCW      = $clog2(LOCK_CYCLES + 1);

   logic [15:0]  regs [128];
   logic [15:0]  din, dout, rd_data, rd_word;
   logic [6:0]   daddr;
   logic         den, dwe, rst_mmcm, addr_ok;
   logic         busy, drdy, rd_pend, locked;
   logic [3:0]   lat_cnt;
   logic [LCW-1:0] lock_cnt;
   lock_state_t  lock_state;
   logic [6:0]   dec_out0, dec_fb, dec_divclk;
   logic         unused_bits;

   assign din         = reconfig_to_pll[DIN_LSB +: 16];
   assign daddr       = reconfig_to_pll[DADDR_LSB +: 7];
   assign den         = reconfig_to_pll[DEN_BIT];
   assign dwe         = reconfig_to_pll[DWE_BIT];
   assign rst_mmcm    = reconfig_to_pll[RST_BIT];
   assign unused_bits = ^reconfig_to_pll[63:26];

`ifdef MMCM_DRP_ADDR_CHECK_EN
   assign addr_ok = addr_legal(daddr);
`else
   assign addr_ok = 1'b1;
`endif

   assign rd_word = addr_ok ? regs[daddr] : 16'h0000;

   always_comb begin
      reconfig_from_pll                 = '0;
      reconfig_from_pll[DOUT_LSB +: 16] = dout;
      reconfig_from_pll[DRDY_BIT]       = drdy;
      reconfig_from_pll[LOCKED_BIT]     = locked;
   end

   // A den seen while busy (including the drdy cycle) only raises the sticky error.
   always_ff @(posedge mgmt_clk) begin
      if (!mgmt_reset_n) begin
         busy    <= 1'b0;
         drdy    <= 1'b0;
         rd_pend <= 1'b0;
         lat_cnt <= 4'd0;
         dout    <= 16'h0000;
         rd_data <= 16'h0000;
         drp_err <= 1'b0;
         for (int i = 0; i < 128; i++) regs[i] <= reset_word(7'(i));
      end else if (busy) begin
         if (den) drp_err <= 1'b1;
         if (drdy) begin
            busy <= 1'b0;
            drdy <= 1'b0;
         end else begin
            lat_cnt <= lat_cnt - 4'd1;
            if (lat_cnt == 4'd1) begin
               drdy <= 1'b1;
               if (rd_pend) dout <= rd_data;
            end
         end
      end else if (den) begin
         busy    <= 1'b1;
         lat_cnt <= LAT_LOAD;
         rd_pend <= !dwe;
         rd_data <= rd_word;
         if (!addr_ok) drp_err <= 1'b1;
         if (dwe && addr_ok) regs[daddr] <= din;
         if (DRDY_LATENCY == 1) begin
            drdy <= 1'b1;
            if (!dwe) dout <= rd_word;
         end
      end
   end

   mmcm_div_decode u_dec_out0 (
      .high     (regs[CLKOUT0_REG1][HIGH_LSB +: 6]),
      .low      (regs[CLKOUT0_REG1][LOW_LSB +: 6]),
      .no_count (regs[CLKOUT0_REG2][NOCOUNT_BIT]),
      .divide   (dec_out0)
   );

   mmcm_div_decode u_dec_fb (
      .high     (regs[CLKFB_REG1][HIGH_LSB +: 6]),
      .low      (regs[CLKFB_REG1][LOW_LSB +: 6]),
      .no_count (regs[CLKFB_REG2][NOCOUNT_BIT]),
      .divide   (dec_fb)
   );

   mmcm_div_decode u_dec_divclk (
      .high     (regs[DIVCLK_REG][HIGH_LSB +: 6]),
      .low      (regs[DIVCLK_REG][LOW_LSB +: 6]),
      .no_count (regs[DIVCLK_REG][DIVCLK_NOCOUNT_BIT]),
      .divide   (dec_divclk)
   );

   // The rst_mmcm fall cycle counts as the first lock cycle, so the load is one short.
   always_ff @(posedge mgmt_clk) begin
      if (!mgmt_reset_n) begin
         lock_state <= LOCK_COUNT;
         lock_cnt   <= LCW'(LOCK_CYCLES);
         locked     <= 1'b0;
         out0_div   <= 7'd1;
         fb_mult    <= 7'd1;
         divclk_div <= 7'd1;
      end else begin
         case (lock_state)
            LOCK_LOCKED: begin
               if (rst_mmcm) begin
                  lock_state <= LOCK_RESET;
                  locked     <= 1'b0;
               end
            end
            LOCK_RESET: begin
               if (!rst_mmcm) begin
                  out0_div   <= dec_out0;
                  fb_mult    <= dec_fb;
                  divclk_div <= dec_divclk;
                  if (LOCK_CYCLES == 1) begin
                     lock_state <= LOCK_LOCKED;
                     locked     <= 1'b1;
                  end else begin
                     lock_state <= LOCK_COUNT;
                     lock_cnt   <= LCW'(LOCK_CYCLES - 1);
                  end
               end
            end
            LOCK_COUNT: begin
               if (rst_mmcm) begin
                  lock_state <= LOCK_RESET;
               end else if (lock_cnt == LCW'(1)) begin
                  lock_state <= LOCK_LOCKED;
                  locked     <= 1'b1;
               end else begin
                  lock_cnt <= lock_cnt - LCW'(1);
               end
            end
            default: lock_state <= LOCK_RESET;
         endcase
      end
   end
endmodule

// File: tb/tb_mmcm_drp_responder.sv
// Bench for mmcm_drp_responder: directed bring-up sequences with literal expectations
// plus randomized DRP/rst_mmcm traffic checked every cycle against a transaction-level model.
module tb_mmcm_drp_responder;
   localparam int L  = 3;
   localparam int LC = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] din;
   logic [6:0]  daddr;
   logic        den, dwe, rst_mmcm, dclk_in;
   logic [36:0] junk;
   logic [63:0] to_pll, from_pll;
   logic [6:0]  out0_div, fb_mult, divclk_div;
   logic        drp_err;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   assign to_pll = {junk, dclk_in, rst_mmcm, dwe, den, daddr, din};

   mmcm_drp_responder #(.DRDY_LATENCY(L), .LOCK_CYCLES(LC)) dut (
      .mgmt_clk          (clk),
      .mgmt_reset_n      (rst_n),
      .reconfig_to_pll   (to_pll),
      .reconfig_from_pll (from_pll),
      .out0_div          (out0_div),
      .fb_mult           (fb_mult),
      .divclk_div        (divclk_div),
      .drp_err           (drp_err)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit legal(input logic [6:0] a);
`ifdef MMCM_DRP_ADDR_CHECK_EN
      return (a >= 7'd6 && a <= 7'd22) || (a >= 7'd24 && a <= 7'd26) ||
             a == 7'd40 || a == 7'd78 || a == 7'd79;
`else
      return (a <= 7'd127);
`endif
   endfunction

   function automatic logic [6:0] div_of(input logic [15:0] r, input logic nc);
      int h, l, s;
      h = (int'(r) >> 6) & 63;
      l = int'(r) & 63;
      if (h == 0) h = 64;
      if (l == 0) l = 64;
      s = h + l;
      if (s > 127) s = 127;
      return nc ? 7'd1 : 7'(s);
   endfunction

   // ---------------- reference model ----------------
   logic [15:0] m_reg [128];
   int          cyc = 0;
   int          m_drdy_at, m_start;
   bit          m_pend, m_is_read, m_in_reset, m_valid = 0;
   logic [15:0] m_rdat, e_dout;
   logic        e_drdy, e_locked, e_err;
   logic [6:0]  e_out0, e_fb, e_div;

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 128; i++) m_reg[i] = 16'h0000;
         m_reg[8]  = 16'h0041; m_reg[9]  = 16'h0040;
         m_reg[20] = 16'h0041; m_reg[21] = 16'h0040;
         m_reg[22] = 16'h1041;
         m_pend = 0; m_in_reset = 0; m_start = cyc + 1; m_drdy_at = -1;
         e_dout = 0; e_drdy = 0; e_locked = 0; e_err = 0;
         e_out0 = 1; e_fb = 1; e_div = 1;
         m_valid = 1;
      end else if (m_valid) begin
         if (rst_mmcm) m_in_reset = 1;
         else if (m_in_reset) begin
            m_in_reset = 0;
            m_start    = cyc;
            e_out0 = div_of(m_reg[8],  m_reg[9][6]);
            e_fb   = div_of(m_reg[20], m_reg[21][6]);
            e_div  = div_of(m_reg[22], m_reg[22][12]);
         end
         e_locked = !m_in_reset && ((cyc + 1 - m_start) >= LC);
         if (den) begin
            if (m_pend && cyc <= m_drdy_at) e_err = 1;
            else begin
               m_pend = 1; m_drdy_at = cyc + L; m_is_read = !dwe;
               if (!legal(daddr)) e_err = 1;
               if (dwe) begin
                  if (legal(daddr)) m_reg[daddr] = din;
               end else m_rdat = legal(daddr) ? m_reg[daddr] : 16'h0000;
            end
         end
         e_drdy = m_pend && (m_drdy_at == cyc + 1);
         if (e_drdy && m_is_read) e_dout = m_rdat;
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("dout",       64'(from_pll[15:0]), 64'(e_dout));
         chk("drdy",       64'(from_pll[16]),   64'(e_drdy));
         chk("locked",     64'(from_pll[17]),   64'(e_locked));
         chk("upper_zero", 64'(from_pll[63:18]), 64'd0);
         chk("drp_err",    64'(drp_err),        64'(e_err));
         chk("out0_div",   64'(out0_div),       64'(e_out0));
         chk("fb_mult",    64'(fb_mult),        64'(e_fb));
         chk("divclk_div", 64'(divclk_div),     64'(e_div));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      junk    = {$urandom, 5'($urandom)};
      dclk_in = 1'($urandom);
   endtask

   task automatic drp_op(input logic [6:0] a, input logic [15:0] d, input bit we,
                         input bit chk_rd, input logic [15:0] exp_rd);
      daddr = a; din = d; dwe = we; den = 1;
      tick();
      den = 0; dwe = 0; din = 16'($urandom); daddr = 7'($urandom);
      for (int i = 1; i <= L; i++) begin
         chk("drdy_latency", 64'(from_pll[16]), (i == L) ? 64'd1 : 64'd0);
         if (i == L && chk_rd) chk("read_data", 64'(from_pll[15:0]), 64'(exp_rd));
         tick();
      end
      chk("drdy_single", 64'(from_pll[16]), 64'd0);
   endtask

   task automatic do_reset(input int n);
      rst_n = 0; den = 0; dwe = 0; rst_mmcm = 0;
      repeat (n) tick();
      rst_n = 1;
   endtask

   initial begin
      int drdy_seen;
      rst_n = 0; den = 0; dwe = 0; rst_mmcm = 0; din = 0; daddr = 0; junk = 0; dclk_in = 0;
      repeat (3) tick();
      chk("rst_out0", 64'(out0_div), 64'd1);
      chk("rst_fb",   64'(fb_mult),  64'd1);
      chk("rst_div",  64'(divclk_div), 64'd1);
      chk("rst_locked", 64'(from_pll[17]), 64'd0);
      chk("rst_from", from_pll, 64'd0);
      chk("rst_err", 64'(drp_err), 64'd0);
      rst_n = 1;
      repeat (63) tick();
      chk("lock_before_64", 64'(from_pll[17]), 64'd0);
      tick();
      chk("lock_at_64", 64'(from_pll[17]), 64'd1);

      drp_op(7'h08, 16'h0145, 1, 0, 0);
      drp_op(7'h08, 16'h0000, 0, 1, 16'h0145);

      rst_mmcm = 1;
      tick();
      drp_op(7'h09, 16'h0000, 1, 0, 0);
      drp_op(7'h08, 16'h0104, 1, 0, 0);
      drp_op(7'h14, 16'h0208, 1, 0, 0);
      drp_op(7'h15, 16'h0000, 1, 0, 0);
      drp_op(7'h16, 16'h0041, 1, 0, 0);
      chk("hold_out0", 64'(out0_div), 64'd1);
      chk("hold_fb",   64'(fb_mult),  64'd1);
      chk("hold_div",  64'(divclk_div), 64'd1);
      chk("locked_in_reset", 64'(from_pll[17]), 64'd0);
      rst_mmcm = 0;
      tick();
      chk("cfg_out0", 64'(out0_div), 64'd8);
      chk("cfg_fb",   64'(fb_mult),  64'd16);
      chk("cfg_div",  64'(divclk_div), 64'd2);
      repeat (62) tick();
      chk("relock_before", 64'(from_pll[17]), 64'd0);
      tick();
      chk("relock_at_64", 64'(from_pll[17]), 64'd1);

      daddr = 7'h11; dwe = 0; den = 1;
      tick();
      daddr = 7'h10; din = 16'h1234; dwe = 1; den = 1;
      tick();
      den = 0; dwe = 0;
      drdy_seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (from_pll[16]) drdy_seen++;
         tick();
      end
      chk("busy_single_drdy", 64'(drdy_seen), 64'd1);
      chk("busy_err", 64'(drp_err), 64'd1);
      drp_op(7'h10, 16'h0000, 0, 1, 16'h0000);
      chk("err_sticky", 64'(drp_err), 64'd1);

      rst_mmcm = 1; tick(); rst_mmcm = 0;
      repeat (40) tick();
      chk("count40_unlocked", 64'(from_pll[17]), 64'd0);
      rst_mmcm = 1; tick(); rst_mmcm = 0;
      repeat (63) tick();
      chk("pulse_before", 64'(from_pll[17]), 64'd0);
      tick();
      chk("pulse_at_64", 64'(from_pll[17]), 64'd1);

      daddr = 7'h08; dwe = 0; den = 1;
      tick();
      den = 0;
      do_reset(2);
      chk("reset_cancel_drdy", 64'(from_pll[16]), 64'd0);
      chk("reset_clear_err", 64'(drp_err), 64'd0);
      drp_op(7'h08, 16'h0000, 0, 1, 16'h0041);
      drp_op(7'h16, 16'h0000, 0, 1, 16'h1041);

      drp_op(7'h30, 16'hBEEF, 1, 0, 0);
`ifdef MMCM_DRP_ADDR_CHECK_EN
      drp_op(7'h30, 16'h0000, 0, 1, 16'h0000);
      chk("addr_err", 64'(drp_err), 64'd1);
`else
      drp_op(7'h30, 16'h0000, 0, 1, 16'hBEEF);
      chk("addr_err", 64'(drp_err), 64'd0);
`endif

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 399) == 0) begin
            rst_n = 0;
         end else begin
            rst_n = 1;
         end
         den = ($urandom_range(0, 3) == 0);
         dwe = 1'($urandom);
         din = 16'($urandom);
         case ($urandom_range(0, 7))
            0: daddr = 7'h08;
            1: daddr = 7'h09;
            2: daddr = 7'h14;
            3: daddr = 7'h15;
            4: daddr = 7'h16;
            default: daddr = 7'($urandom);
         endcase
         if (rst_mmcm) rst_mmcm = ($urandom_range(0, 2) != 0);
         else          rst_mmcm = ($urandom_range(0, 149) == 0);
         tick();
      end
      rst_n = 1; den = 0; rst_mmcm = 0;
      repeat (5) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/mmcm_drp_responder.md
Name: mmcm_drp_responder

Overview:
Synthesizable responder for the Xilinx 7-series MMCM DRP port, seen from the PLL side of the reconfig_to_pll/reconfig_from_pll bundles. It models the register file, drdy timing, the reset-triggered config update and the locked behaviour. Used in simulation and on bring-up builds to exercise the Avalon-MM PLL reconfig path without a real MMCM. It also exposes the decoded divider settings that currently apply.

Parameters:
DRDY_LATENCY, 3, cycles from den to drdy; legal range 1..15.
LOCK_CYCLES, 64, cycles from rst_mmcm deassertion (or mgmt_reset_n release) to locked=1; must be >=1.

Ports:
mgmt_clk  in  1  single clock; also serves as DRP dclk.
mgmt_reset_n  in  1  synchronous, active-low reset.
reconfig_to_pll  in  64  [15:0] din, [22:16] daddr, [23] den, [24] dwe, [25] rst_mmcm, [26] dclk (ignored), [63:27] ignored.
reconfig_from_pll  out  64  [15:0] dout, [16] drdy, [17] locked, [63:18] constant 0.
out0_div  out  7  applied CLKOUT0 divide.
fb_mult  out  7  applied CLKFBOUT multiply.
divclk_div  out  7  applied DIVCLK divide.
drp_err  out  1  sticky protocol-violation flag.

Behaviour:
- Register file: 128 x 16, addressed by daddr.
- Reset contents:
  - 0x08 = 16'h0041, 0x09 = 16'h0040 (CLKOUT0 no_count).
  - 0x14 = 16'h0041, 0x15 = 16'h0040 (CLKFBOUT no_count).
  - 0x16 = 16'h1041 (DIVCLK no_count).
  - All other words 0.
- Output reset values: dout=0, drdy=0, locked=0, drp_err=0, out0_div=fb_mult=divclk_div=1.
- Idle state, den=1:
  - Transaction accepted.
  - dwe=1: din written to regfile[daddr] at the end of that cycle.
  - dwe=0: regfile[daddr] captured into a read-data register.
  - Move to BUSY, load the latency counter.
- BUSY: drdy=1 for exactly one cycle, DRDY_LATENCY cycles after the den cycle (latency 1 means drdy in the cycle after den).
  - Read: dout shows the captured data in the drdy cycle. dout holds its last value afterwards.
  - Write: dout is unchanged.
  - Return to IDLE in the cycle after drdy.
  - den in the drdy cycle is still a violation; a new den is legal only once drdy has dropped.
- den while BUSY: ignored (no write, no timing change) and drp_err set. drp_err clears only on reset.
- Lock state machine: LOCKED -> RESET (rst_mmcm=1) -> COUNT (rst_mmcm=0) -> LOCKED.
  - locked=0 in RESET and COUNT.
  - COUNT lasts LOCK_CYCLES cycles, then locked=1.
  - rst_mmcm reasserting during COUNT returns to RESET; the count restarts on the next fall.
  - After mgmt_reset_n releases, the block enters COUNT.
- DRP is served regardless of lock state; rst_mmcm and den in the same cycle are both honoured.
- Applied config: out0_div, fb_mult and divclk_div are decoded from the regfile in the first cycle of COUNT only. They are not updated by writes while locked or in RESET.
- Divider decode: divide = no_count ? 1 : high + low, where a high or low field of 0 counts as 64. The sum saturates at 127.
  - CLKOUT0: high = 0x08[11:6], low = 0x08[5:0], no_count = 0x09[6].
  - CLKFBOUT: same fields in 0x14 / 0x15.
  - DIVCLK: high = 0x16[11:6], low = 0x16[5:0], no_count = 0x16[12].
  - Edge bits are stored but not decoded.
- mgmt_reset_n=0 in any state: pending drdy cancelled, regfile reinitialised, all outputs go to reset values on the next edge.

Optional Feature:
- Macro: MMCM_DRP_ADDR_CHECK_EN.
- Defined: only these addresses are legal: 0x06–0x16, 0x18–0x1A, 0x28, 0x4E, 0x4F.
  - Write to any other address: dropped and sets drp_err; drdy still returned.
  - Read from any other address: returns 16'h0000 and sets drp_err.
- Undefined: all 128 addresses are read/write and drp_err flags busy violations only.

Decomposition:
- Package mmcm_drp_pkg holds:
  - bundle bit positions (DIN_LSB, DADDR_LSB, DEN_BIT, DWE_BIT, RST_BIT, DRDY_BIT, LOCKED_BIT);
  - DRP address constants (CLKOUT0_REG1/2, CLKFB_REG1/2, DIVCLK_REG, LOCK_REG1..3, POWER_REG, FILT_REG1/2);
  - field bit positions;
  - lock-state enum.
- One sub-module, mmcm_div_decode: combinational high/low/no_count -> 7-bit divide, instantiated 3x.

Test Plan:
- Reset release, no traffic -> locked=0 for 64 cycles then 1; out0_div=fb_mult=divclk_div=1.
- Write 0x08=16'h0145, read 0x08 -> drdy exactly 3 cycles after each den; read dout=16'h0145.
- Write 0x09=0, 0x08=16'h0104, 0x14=16'h0208, 0x15=0, 0x16=16'h0041 under rst_mmcm=1, then drop rst_mmcm:
  - decoded outputs stay 1 until rst_mmcm falls;
  - out0_div=8, fb_mult=16, divclk_div=2 from the first cycle of COUNT;
  - locked rises 64 cycles after the fall.
- Second den 1 cycle after the first -> ignored, single drdy, drp_err=1 until reset.
- rst_mmcm pulsed at count 40 of COUNT -> locked rises 64 cycles after the second fall.
- With MMCM_DRP_ADDR_CHECK_EN: write 0x30=16'hBEEF then read 0x30 -> dout=0, drp_err=1. Without the macro: dout=16'hBEEF, drp_err=0.
